// File: rtl/cle_pkg.sv
// Shared types and constants for the blob statistics block.
// Records, coordinates and the FSM state encoding live here.
package cle_pkg;

  localparam int IMG_W   = 32;
  localparam int ADDR_W  = 10;
  localparam int LBL_W   = 8;
  localparam int AREA_W  = 11;
  localparam int COORD_W = 5;
  localparam int MAX_OBJ = 8;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 4;

  localparam logic [ADDR_W-1:0] LAST_A =
    ADDR_W'(IMG_W * IMG_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_EMIT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
  } rc_t;

  typedef struct packed {
    logic [LBL_W-1:0]   label;
    logic [AREA_W-1:0]  area;
    logic [COORD_W-1:0] rmin;
    logic [COORD_W-1:0] rmax;
    logic [COORD_W-1:0] cmin;
    logic [COORD_W-1:0] cmax;
    logic               vld;
  } obj_rec_t;

  function automatic rc_t addr_to_rc(
    input logic [ADDR_W-1:0] a
  );
    rc_t rc;
    rc.row = a[ADDR_W-1:COORD_W];
    rc.col = a[COORD_W-1:0];
    return rc;
  endfunction

endpackage

// File: rtl/cle_blob_stats_if.sv
// Object record stream: valid/ready plus the record fields.
// The producer drives fields and valid; the consumer drives ready.
interface cle_blob_stats_if;
  import cle_pkg::*;

  logic               out_valid;
  logic               out_ready;
  logic [LBL_W-1:0]   out_label;
  logic [AREA_W-1:0]  out_area;
  logic [COORD_W-1:0] out_rmin;
  logic [COORD_W-1:0] out_rmax;
  logic [COORD_W-1:0] out_cmin;
  logic [COORD_W-1:0] out_cmax;

  modport master (
    output out_valid,
    output out_label,
    output out_area,
    output out_rmin,
    output out_rmax,
    output out_cmin,
    output out_cmax,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_label,
    input  out_area,
    input  out_rmin,
    input  out_rmax,
    input  out_cmin,
    input  out_cmax,
    output out_ready
  );

endinterface

// File: rtl/cle_obj_table.sv
// Flop-based object table: parallel label match, in-order allocation,
// single-cycle area/bounding-box update and an indexed read port.
module cle_obj_table
  import cle_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             pix_vld_i,
  input  logic [LBL_W-1:0] lbl_i,
  input  rc_t              rc_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output obj_rec_t         rd_rec_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             ovf_o
);

  obj_rec_t         tbl_q [MAX_OBJ];
  obj_rec_t         tbl_d [MAX_OBJ];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [MAX_OBJ-1:0] hit;

  always_comb begin
    tbl_d = tbl_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    hit   = '0;
    for (int i = 0; i < MAX_OBJ; i++)
      hit[i] = tbl_q[i].vld &&
               (tbl_q[i].label == lbl_i);
    if (clr_i) begin
      for (int i = 0; i < MAX_OBJ; i++)
        tbl_d[i] = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (pix_vld_i && lbl_i != '0) begin
      if (|hit) begin
        for (int i = 0; i < MAX_OBJ; i++) begin
          if (hit[i]) begin
            tbl_d[i].area = tbl_q[i].area + AREA_W'(1);
            if (rc_i.row < tbl_q[i].rmin)
              tbl_d[i].rmin = rc_i.row;
            if (rc_i.row > tbl_q[i].rmax)
              tbl_d[i].rmax = rc_i.row;
            if (rc_i.col < tbl_q[i].cmin)
              tbl_d[i].cmin = rc_i.col;
            if (rc_i.col > tbl_q[i].cmax)
              tbl_d[i].cmax = rc_i.col;
          end
        end
      end else if (cnt_q < CNT_W'(MAX_OBJ)) begin
        tbl_d[cnt_q[IDX_W-1:0]] = '{
          label: lbl_i,
          area:  AREA_W'(1),
          rmin:  rc_i.row,
          rmax:  rc_i.row,
          cmin:  rc_i.col,
          cmax:  rc_i.col,
          vld:   1'b1
        };
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OBJ; i++)
        tbl_q[i] <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      tbl_q <= tbl_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign rd_rec_o  = tbl_q[rd_idx_i];
  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/cle_blob_stats.sv
// Raster-scans the label SRAM, accumulates per-label stats and
// streams one record per object in first-seen order.
module cle_blob_stats
  import cle_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LBL_W-1:0]  sram_q,
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_wen,
  output logic              busy,
  output logic [CNT_W-1:0]  obj_count,
  output logic              overflow,
  output logic              done,
  cle_blob_stats_if.master  rec
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pix_q;
  rc_t               rc_q;
  logic              clr;
  obj_rec_t          rd_rec, shown;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              unused_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      pix_q   <= 1'b0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      pix_q   <= (state_q == S_SCAN);
      rc_q    <= addr_to_rc(addr_q);
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_SCAN;
        clr     = 1'b1;
        addr_d  = '0;
        idx_d   = '0;
      end
      S_SCAN: begin
        addr_d = addr_q + ADDR_W'(1);
        if (addr_q == LAST_A)
          state_d = S_DRAIN;
      end
      // last pixel lands this cycle, so look at the next count
      S_DRAIN:
        state_d = (cnt_nxt == '0) ? S_DONE : S_EMIT;
      S_EMIT: if (rec.out_ready) begin
        if (CNT_W'(idx_q) + CNT_W'(1) == obj_count) begin
          state_d = S_DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  cle_obj_table u_tbl (
    .clk       (clk),
    .rst_n     (reset),
    .clr_i     (clr),
    .pix_vld_i (pix_q),
    .lbl_i     (sram_q),
    .rc_i      (rc_q),
    .rd_idx_i  (idx_q),
    .rd_rec_o  (rd_rec),
    .cnt_o     (obj_count),
    .cnt_nxt_o (cnt_nxt),
    .ovf_o     (overflow)
  );

  assign sram_a   = addr_q;
  assign sram_wen = 1'b1;
  assign busy     = (state_q == S_SCAN)  ||
                    (state_q == S_DRAIN) ||
                    (state_q == S_EMIT);
  assign done     = (state_q == S_DONE);

  assign rec.out_valid = (state_q == S_EMIT);
  assign shown = rec.out_valid ? rd_rec : '0;
  assign unused_vld = shown.vld;

  assign rec.out_label = shown.label;
  assign rec.out_area  = shown.area;
  assign rec.out_rmin  = shown.rmin;
  assign rec.out_rmax  = shown.rmax;
  assign rec.out_cmin  = shown.cmin;
  assign rec.out_cmax  = shown.cmax;

endmodule

// File: tb/tb_cle_blob_stats.sv
// Bench for cle_blob_stats: SRAM model, reference stats model,
// directed and random label maps with several ready patterns.
module tb_cle_blob_stats;
  import cle_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  sram_q;
  logic [9:0]  sram_a;
  logic        sram_wen;
  logic        busy;
  logic [3:0]  obj_count;
  logic        overflow;
  logic        done;

  cle_blob_stats_if ifc ();

  cle_blob_stats dut (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start),
    .sram_q    (sram_q),
    .sram_a    (sram_a),
    .sram_wen  (sram_wen),
    .busy      (busy),
    .obj_count (obj_count),
    .overflow  (overflow),
    .done      (done),
    .rec       (ifc)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1024];

  always @(posedge clk) sram_q <= mem[sram_a];

  int n_cmp = 0;
  int n_bad = 0;

  int e_lab [8];
  int e_area[8];
  int e_r0  [8];
  int e_r1  [8];
  int e_c0  [8];
  int e_c1  [8];
  int e_n;
  int e_ovf;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Per-object stats straight from the raster definition.
  task automatic build_model();
    int f, r, c, l;
    e_n = 0;
    e_ovf = 0;
    for (int k = 0; k < 1024; k++) begin
      l = int'(mem[k]);
      if (l == 0) continue;
      r = k / 32;
      c = k % 32;
      f = -1;
      for (int j = 0; j < e_n; j++)
        if (e_lab[j] == l) f = j;
      if (f >= 0) begin
        e_area[f]++;
        if (r < e_r0[f]) e_r0[f] = r;
        if (r > e_r1[f]) e_r1[f] = r;
        if (c < e_c0[f]) e_c0[f] = c;
        if (c > e_c1[f]) e_c1[f] = c;
      end else if (e_n < 8) begin
        e_lab[e_n] = l;
        e_area[e_n] = 1;
        e_r0[e_n] = r; e_r1[e_n] = r;
        e_c0[e_n] = c; e_c1[e_n] = c;
        e_n++;
      end else begin
        e_ovf = 1;
      end
    end
  endtask

  function automatic logic [38:0] rec_obs();
    return {ifc.out_label, ifc.out_area,
            ifc.out_rmin, ifc.out_rmax,
            ifc.out_cmin, ifc.out_cmax};
  endfunction

  function automatic logic [38:0] rec_exp(int g);
    if (g >= e_n) return '1;
    return {8'(e_lab[g]), 11'(e_area[g]),
            5'(e_r0[g]), 5'(e_r1[g]),
            5'(e_c0[g]), 5'(e_c1[g])};
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_a"},    sram_a, 0);
    chk({tag, "_wen"},  sram_wen, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_vld"},  ifc.out_valid, 0);
    chk({tag, "_rec"},  rec_obs(), 0);
    chk({tag, "_cnt"},  obj_count, 0);
    chk({tag, "_ovf"},  overflow, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // mode 0: ready=1, mode 1: random ready, mode 2: 5-cycle stall
  task automatic run(input int mode, input string nm);
    int n, got, bp, done_n, last, sweep_bad, exp_done;
    build_model();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1; got = 0; bp = 0;
    done_n = -1; last = -1; sweep_bad = 0;
    while (n < 12000) begin
      if (n <= 1024 &&
          (sram_a !== 10'(n - 1) || busy !== 1'b1))
        sweep_bad++;
      if (done === 1'b1) begin
        done_n = n;
        break;
      end
      if (mode == 1)
        ifc.out_ready = 1'($urandom_range(0, 1));
      else
        ifc.out_ready = 1'b1;
      if (ifc.out_valid === 1'b1) begin
        if (mode == 2 && bp < 5) begin
          ifc.out_ready = 1'b0;
          chk({nm, "_hold"}, rec_obs(), rec_exp(got));
          bp++;
        end
        if (ifc.out_ready) begin
          chk({nm, "_rec"}, rec_obs(), rec_exp(got));
          got++;
          last = n;
        end
      end
      @(negedge clk);
      n++;
    end
    ifc.out_ready = 1'b1;
    chk({nm, "_sweep"}, sweep_bad, 0);
    chk({nm, "_done_seen"}, done_n != -1, 1);
    chk({nm, "_nrec"}, got, e_n);
    chk({nm, "_cnt"}, obj_count, e_n);
    chk({nm, "_ovf"}, overflow, e_ovf);
    if (mode != 1) begin
      exp_done = 1026 + e_n;
      if (mode == 2 && e_n > 0) exp_done += 5;
      chk({nm, "_done_t"}, done_n, exp_done);
    end
    if (e_n > 0)
      chk({nm, "_done_after"}, done_n, last + 1);
    @(negedge clk);
    chk({nm, "_pulse"}, done, 0);
    chk({nm, "_idle"}, busy, 0);
  endtask

  task automatic clear_map();
    for (int k = 0; k < 1024; k++) mem[k] = 8'h00;
  endtask

  task automatic two_obj_map();
    clear_map();
    for (int r = 2; r <= 4; r++)
      for (int c = 5; c <= 7; c++)
        mem[r * 32 + c] = 8'h03;
    mem[10 * 32 + 1] = 8'hA0;
    mem[11 * 32 + 1] = 8'hA0;
    mem[11 * 32 + 2] = 8'hA0;
  endtask

  task automatic rand_map(input int dens, input int maxl);
    for (int k = 0; k < 1024; k++)
      if ($urandom_range(0, 99) < dens)
        mem[k] = 8'($urandom_range(1, maxl));
      else
        mem[k] = 8'h00;
  endtask

  initial begin
    int w;
    ifc.out_ready = 1'b1;
    clear_map();
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    run(0, "zero");

    clear_map();
    mem[1023] = 8'h05;
    run(0, "last_px");
    chk("last_px_ref", {e_lab[0], e_area[0], e_r0[0], e_c1[0]},
        {32'd5, 32'd1, 32'd31, 32'd31});

    for (int k = 0; k < 1024; k++) mem[k] = 8'h01;
    run(0, "full");
    chk("full_ref_area", e_area[0], 1024);

    two_obj_map();
    run(0, "two");

    clear_map();
    for (int k = 0; k < 9; k++)
      mem[k * 100 + 7] = 8'(k + 1);
    run(1, "nine");

    two_obj_map();
    run(2, "bp");

    rand_map(40, 200);
    run(2, "bp_rand");

    // reset while scanning address 500
    rand_map(30, 6);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (sram_a !== 10'd500 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("rst_mid_reach", sram_a, 500);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    w = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) w++;
    end
    chk("rst_mid_quiet", w, 0);
    run(0, "after_rst");

    rand_map(50, 12);
    run(1, "rnd_a");
    rand_map(90, 4);
    run(0, "rnd_b");
    rand_map(5, 255);
    run(1, "rnd_c");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cle_blob_stats.md
Name: cle_blob_stats

Overview:
- Downstream of the component labeling engine.
- Once labeling finishes, it raster-scans the 32x32 label map in the 1024x8 label SRAM, one read per cycle.
- For each distinct nonzero label it accumulates pixel area and bounding box.
- It then streams one record per object over a valid/ready port to the host/report logic.

Parameters:
- MAX_OBJ, 8: number of object table entries (distinct nonzero labels tracked).
- IMG_W, 32: image width/height in pixels; must be a power of two; SRAM depth is IMG_W*IMG_W.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  one-cycle pulse, tied to the engine's finish; sampled only in IDLE.
- sram_q  in  8  label SRAM read data; valid the cycle after sram_a is presented.
- sram_a  out  10  label SRAM address, row*32+col.
- sram_wen  out  1  held 1 (read only).
- busy  out  1  high in SCAN, DRAIN and EMIT.
- out_valid  out  1  record valid.
- out_ready  in  1  consumer accepts the record.
- out_label  out  8  object label value.
- out_area  out  11  pixel count, 1..1024.
- out_rmin, out_rmax, out_cmin, out_cmax  out  5 each  bounding box rows/cols, inclusive.
- obj_count  out  4  number of entries allocated, saturating at MAX_OBJ.
- overflow  out  1  sticky; set when a new label is seen while the table is full.
- done  out  1  one-cycle pulse after the last record is accepted.

Behaviour:
- Reset: all outputs 0 except sram_wen=1. State IDLE. Table entries invalid. Reset mid-operation aborts immediately; no done pulse follows.
- States:
  - IDLE: start=1 -> SCAN, clearing the table, obj_count and overflow.
  - SCAN: sram_a=0,1,...,1023, one per cycle; after issuing 1023 -> DRAIN.
  - DRAIN: one cycle to consume the last read datum -> EMIT (or DONE if obj_count=0).
  - EMIT: presents entries in allocation order -> DONE after the last entry is accepted.
  - DONE: done=1 for one cycle -> IDLE.
- Read pipeline:
  - Address k issued in cycle t; sram_q for k processed in cycle t+1.
  - Row = k[9:5] and col = k[4:0] are delayed one cycle alongside.
  - Total SCAN+DRAIN = 1025 cycles.
- Per pixel, label L = sram_q:
  - L=0: ignored.
  - L matches a valid entry: area+1, rmin=min, rmax=max, cmin=min, cmax=max, all updated in the same cycle.
  - No match and table not full: allocate the next free entry with area=1 and box = (row,row,col,col).
  - No match and table full: overflow=1, pixel dropped.
- Consecutive pixels with the same label need no stall; the table is flops with single-cycle read-modify-write.
- Allocation order is raster first-seen order, which is also the emit order.
- Emit handshake:
  - out_valid high throughout EMIT.
  - Record fields stable while out_valid=1 and out_ready=0.
  - Transfer on out_valid & out_ready; the next entry is presented the following cycle.
  - Throughput is one record per cycle with out_ready held 1.
- obj_count and overflow hold their values from the end of SCAN until the next start.
- start while busy or in DONE: ignored.
- Width rules: area is 11 bits and cannot wrap (max 1024); row/col are unsigned 5-bit.

Decomposition:
- Shared package cle_pkg:
  - IMG_W, ADDR_W=10, LBL_W=8, AREA_W=11, COORD_W=5.
  - Typedef obj_rec_t {label, area, rmin, rmax, cmin, cmax, vld}.
  - Function addr_to_rc.
- Sub-module cle_obj_table:
  - MAX_OBJ entries with parallel label match, allocate pointer, update datapath and indexed read port for emit.
  - Top holds the FSM, address counter and pipeline registers.

Test Plan:
- All-zero label map, start pulse -> sram_a sweeps 0..1023; no out_valid; done 1026 cycles after start; obj_count=0, overflow=0.
- Single label 0x05 at address 1023 only -> one record: label 05, area 1, box r31..31, c31..31; done after accept.
- Entire map = 0x01 -> one record: area 1024, rmin 0, rmax 31, cmin 0, cmax 31.
- Two objects: 0x03 on rows 2-4 cols 5-7 (area 9), then 0xA0 in an L-shape at r10c1, r11c1, r11c2 -> records in order 03 (9, r2..4, c5..7), A0 (3, r10..11, c1..2).
- Nine distinct labels with MAX_OBJ=8 -> eight records in first-seen order; overflow=1; obj_count=8.
- Backpressure: out_ready=0 for 5 cycles with out_valid high -> record fields unchanged; then out_ready=1 -> one record per cycle.
- Reset asserted at scan address 500 -> all outputs to reset values; no done; a new start rescans from 0 with correct results.
